pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register; the successor to the fixed 16-bit inter-stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries NUM_FIELDS data words of DATA_W bits plus a CTRL_W control bundle.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and a sticky halt latch.
- Placed between any two pipeline stages; replaces per-stage hand-wired dff_16bit banks.

Parameters:
- DATA_W, 16, width of each data field.
- NUM_FIELDS, 7, number of data fields; packed field 0 at LSBs.
- CTRL_W, 16, width of the control bundle.
- CTRL_NOP, 0, control value presented when the stage holds a bubble.
- HALT_BIT, 13, index of the control bit that marks a halt/dump instruction.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- in_valid, input, 1, upstream entry is valid.
- in_ready, output, 1, stage can accept this cycle.
- in_data, input, NUM_FIELDS*DATA_W, packed data fields.
- in_ctrl, input, CTRL_W, control bundle.
- flush, input, 1, synchronous kill of all held entries.
- out_valid, output, 1, out_data/out_ctrl are valid.
- out_ready, input, 1, downstream consumes this cycle.
- out_data, output, NUM_FIELDS*DATA_W, head entry data.
- out_ctrl, output, CTRL_W, head entry control; CTRL_NOP when out_valid=0.
- occupancy, output, 2, number of held entries (0..2; max 1 when SKID=0).
- halted, output, 1, sticky: a halt entry has been accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=CTRL_NOP.
  - Skid entry invalid, occupancy=0, halted=0.
  - in_ready=0 while rst=0; in_ready=1 from the first edge after reset release.
- Definitions:
  - acc = in_valid & in_ready & ~flush.
  - drain = out_valid & out_ready.
- SKID=1, storage:
  - Main register (head, drives outputs) plus skid register.
  - in_ready is registered: in_ready = ~skid_valid & ~halted, as seen after each edge.
- SKID=1, per-edge update (no flush):
  - Head empty or drain, skid valid: head <- skid; skid <- input if acc, else skid invalid.
  - Head empty or drain, skid invalid: head <- input if acc, else head invalid.
  - Head full, no drain, acc: skid <- input (skid was empty by in_ready rule).
  - Head full, no drain, no acc: hold.
- SKID=1, throughput: latency in->out is 1 cycle; full throughput (1 entry/cycle) with out_ready held high.
- SKID=0:
  - in_ready = (~out_valid | out_ready) & ~halted (combinational).
  - Head <- input on acc; head invalid on drain without acc.
- Ordering: entries leave strictly in acceptance order; no entry is duplicated or dropped except by flush.
- Bubble: when out_valid=0, out_ctrl=CTRL_NOP; out_data holds its last value.
- Flush:
  - Next edge: head and skid invalid, occupancy=0, halted=0.
  - The entry offered in the flush cycle is discarded.
  - A drain in the flush cycle still counts as consumed downstream.
- Halt:
  - When acc and in_ctrl[HALT_BIT]=1, halted=1 from the next edge.
  - in_ready then stays 0 until flush or reset.
  - Already-held entries, including the halt entry, still drain normally.
- occupancy = head_valid + skid_valid, updated each edge.
- Simultaneous acc and drain with head full and skid empty: head replaced by the input; occupancy unchanged.
- Reset asserted mid-transfer: all entries lost; no partial state survives.

Test Plan:
- Reset values: hold rst=0 with random inputs. Required: out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occupancy=0, in_ready=0. After release, in_ready=1 on the first edge.
- Streaming: SKID=1, out_ready=1, send 8 entries with field0=1..8 back-to-back. Required: out sees 1..8 on consecutive cycles, each 1 cycle after acceptance; occupancy never exceeds 1.
- Backpressure: out_ready=0, send 0xA1, 0xA2, 0xA3. Required: A1 and A2 accepted, occupancy=2, in_ready=0, A3 held off. Then out_ready=1 yields A1, A2, A3 in order with no loss.
- Flush with skid full: occupancy=2, assert flush with in_valid=1 (0xFF). Required next cycle: out_valid=0, out_ctrl=CTRL_NOP, occupancy=0; 0xFF never appears.
- Halt: send entry with ctrl[13]=1 followed by 0x55. Required: halted=1 and in_ready=0 after acceptance; 0x55 is not accepted; halt entry drains; pulsing flush clears halted and 0x55 is then accepted.
- SKID=0 build: out_ready toggling 1,0,1,0 while in_valid=1. Required: in_ready tracks ~out_valid|out_ready combinationally; occupancy never reaches 2; order is preserved.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a sticky halt latch between two pipeline stages.
module pipe_stage_reg #(
  parameter int                DATA_W     = 16,
  parameter int                NUM_FIELDS = 7,
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP   = '0,
  parameter int                HALT_BIT   = 13,
  parameter int                SKID       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [1:0]                   occupancy,
  output logic                         halted
);

  localparam int W = NUM_FIELDS * DATA_W;

  logic              headValid_q, headValid_d;
  logic [W-1:0]      headData_q, headData_d;
  logic [CTRL_W-1:0] headCtrl_q, headCtrl_d;
  logic              skidValid_q, skidValid_d;
  logic [W-1:0]      skidData_q, skidData_d;
  logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
  logic              halted_q, halted_d;
  logic              inReady_q, inReady_d;
  logic              live_q;

  logic acc;
  logic drain;

  assign drain = headValid_q & out_ready;
  assign acc   = in_valid & in_ready & ~flush;

  // The skid variant presents a registered ready; the single-entry variant
  // lets a downstream drain open the input in the same cycle.
  assign in_ready = (SKID != 0) ? inReady_q
                                : (live_q & (~headValid_q | out_ready) & ~halted_q);

  assign out_valid = headValid_q;
  assign out_data  = headData_q;
  assign out_ctrl  = headValid_q ? headCtrl_q : CTRL_NOP;
  assign occupancy = {1'b0, headValid_q} + {1'b0, skidValid_q};
  assign halted    = halted_q;

  always_comb begin
    headValid_d = headValid_q;
    headData_d  = headData_q;
    headCtrl_d  = headCtrl_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidCtrl_d  = skidCtrl_q;
    halted_d    = halted_q;

    if (flush) begin
      headValid_d = 1'b0;
      skidValid_d = 1'b0;
      halted_d    = 1'b0;
    end else begin
      if (acc && in_ctrl[HALT_BIT]) begin
        halted_d = 1'b1;
      end
      if (SKID != 0) begin
        if (!headValid_q || drain) begin
          if (skidValid_q) begin
            headValid_d = 1'b1;
            headData_d  = skidData_q;
            headCtrl_d  = skidCtrl_q;
            skidValid_d = acc;
            if (acc) begin
              skidData_d = in_data;
              skidCtrl_d = in_ctrl;
            end
          end else begin
            headValid_d = acc;
            if (acc) begin
              headData_d = in_data;
              headCtrl_d = in_ctrl;
            end
          end
        end else if (acc) begin
          skidValid_d = 1'b1;
          skidData_d  = in_data;
          skidCtrl_d  = in_ctrl;
        end
      end else begin
        if (acc) begin
          headValid_d = 1'b1;
          headData_d  = in_data;
          headCtrl_d  = in_ctrl;
        end else if (drain) begin
          headValid_d = 1'b0;
        end
      end
    end

    inReady_d = ~skidValid_d & ~halted_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headValid_q <= 1'b0;
      headData_q  <= '0;
      headCtrl_q  <= CTRL_NOP;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidCtrl_q  <= CTRL_NOP;
      halted_q    <= 1'b0;
      inReady_q   <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      headValid_q <= headValid_d;
      headData_q  <= headData_d;
      headCtrl_q  <= headCtrl_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidCtrl_q  <= skidCtrl_d;
      halted_q    <= halted_d;
      inReady_q   <= inReady_d;
      live_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a table-driven run on the skid build plus
// hand-written sequences for reset and the single-entry build.
module tb_pipe_stage_reg;

  localparam int          DW  = 16;
  localparam int          NF  = 7;
  localparam int          CW  = 16;
  localparam int          W   = DW * NF;
  localparam logic [15:0] NOP = 16'h0F0F;

  typedef struct {
    logic        iv;
    logic        orr;
    logic        fl;
    logic [15:0] f;
    logic [15:0] c;
    logic        eov;
    logic [15:0] eod;
    logic [15:0] eoc;
    logic [1:0]  eocc;
    logic        eir;
    logic        ehl;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         inValid = 1'b0, outReady = 1'b0, flushIn = 1'b0;
  logic [W-1:0] inData = '0;
  logic [CW-1:0] inCtrl = '0;
  logic         inReady, outValid, haltedOut;
  logic [W-1:0] outData;
  logic [CW-1:0] outCtrl;
  logic [1:0]   occ;

  logic         inValid0 = 1'b0, outReady0 = 1'b0, flush0 = 1'b0;
  logic [W-1:0] inData0 = '0;
  logic [CW-1:0] inCtrl0 = '0;
  logic         inReady0, outValid0, halted0;
  logic [W-1:0] outData0;
  logic [CW-1:0] outCtrl0;
  logic [1:0]   occ0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[25];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .CTRL_W(CW), .CTRL_NOP(NOP),
                   .HALT_BIT(13), .SKID(1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_ctrl(inCtrl), .flush(flushIn), .out_valid(outValid), .out_ready(outReady),
    .out_data(outData), .out_ctrl(outCtrl), .occupancy(occ), .halted(haltedOut));

  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .CTRL_W(CW), .CTRL_NOP(NOP),
                   .HALT_BIT(13), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0),
    .in_ctrl(inCtrl0), .flush(flush0), .out_valid(outValid0), .out_ready(outReady0),
    .out_data(outData0), .out_ctrl(outCtrl0), .occupancy(occ0), .halted(halted0));

  // Every field carries a distinct pattern derived from field 0 so swaps show up.
  function automatic logic [W-1:0] mk(input logic [15:0] f);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NF; k++) r[k*DW +: DW] = f + 16'(k << 12);
    return r;
  endfunction

  function automatic vec_t mkv(input logic iv, orr, fl, input logic [15:0] f, c,
                               input logic eov, input logic [15:0] eod, eoc,
                               input logic [1:0] eocc, input logic eir, ehl);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.f = f; v.c = c;
    v.eov = eov; v.eod = eod; v.eoc = eoc; v.eocc = eocc; v.eir = eir; v.ehl = ehl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, orr, fl, input logic [15:0] f, c);
    inValid  = iv;
    outReady = orr;
    flushIn  = fl;
    inData   = mk(f);
    inCtrl   = c;
  endtask

  task automatic drive0(input logic iv, orr, input logic [15:0] f);
    inValid0  = iv;
    outReady0 = orr;
    inData0   = mk(f);
    inCtrl0   = 16'h0100 + f;
  endtask

  initial begin
    // Streaming 1..8 with out_ready high, then a trailing drain.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = mkv(1, 1, 0, 16'(i + 1), 16'h0100 + 16'(i + 1),
                    1, 16'(i + 1), 16'h0100 + 16'(i + 1), 2'd1, 1, 0);
    end
    vecs[8]  = mkv(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0008, NOP,      2'd0, 1, 0);
    // Backpressure: A1 into head, A2 into skid, A3 held off until drained.
    vecs[9]  = mkv(1, 0, 0, 16'h00A1, 16'h01A1, 1, 16'h00A1, 16'h01A1, 2'd1, 1, 0);
    vecs[10] = mkv(1, 0, 0, 16'h00A2, 16'h01A2, 1, 16'h00A1, 16'h01A1, 2'd2, 0, 0);
    vecs[11] = mkv(1, 0, 0, 16'h00A3, 16'h01A3, 1, 16'h00A1, 16'h01A1, 2'd2, 0, 0);
    vecs[12] = mkv(1, 1, 0, 16'h00A3, 16'h01A3, 1, 16'h00A2, 16'h01A2, 2'd1, 1, 0);
    vecs[13] = mkv(1, 1, 0, 16'h00A3, 16'h01A3, 1, 16'h00A3, 16'h01A3, 2'd1, 1, 0);
    vecs[14] = mkv(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h00A3, NOP,      2'd0, 1, 0);
    // Flush with both entries held; the 0xFF offered alongside must vanish.
    vecs[15] = mkv(1, 0, 0, 16'h0010, 16'h0110, 1, 16'h0010, 16'h0110, 2'd1, 1, 0);
    vecs[16] = mkv(1, 0, 0, 16'h0011, 16'h0111, 1, 16'h0010, 16'h0110, 2'd2, 0, 0);
    vecs[17] = mkv(1, 0, 1, 16'h00FF, 16'h01FF, 0, 16'h0010, NOP,      2'd0, 1, 0);
    vecs[18] = mkv(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0010, NOP,      2'd0, 1, 0);
    // Halt entry blocks 0x55 until a flush clears the latch.
    vecs[19] = mkv(1, 0, 0, 16'h0020, 16'h2020, 1, 16'h0020, 16'h2020, 2'd1, 0, 1);
    vecs[20] = mkv(1, 0, 0, 16'h0055, 16'h0155, 1, 16'h0020, 16'h2020, 2'd1, 0, 1);
    vecs[21] = mkv(1, 1, 0, 16'h0055, 16'h0155, 0, 16'h0020, NOP,      2'd0, 0, 1);
    vecs[22] = mkv(1, 1, 1, 16'h0055, 16'h0155, 0, 16'h0020, NOP,      2'd0, 1, 0);
    vecs[23] = mkv(1, 1, 0, 16'h0055, 16'h0155, 1, 16'h0055, 16'h0155, 2'd1, 1, 0);
    vecs[24] = mkv(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0055, NOP,      2'd0, 1, 0);

    // Reset held with random traffic on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'($urandom), 1'($urandom), 1'b0, 16'($urandom), 16'($urandom));
      drive0(1'($urandom), 1'($urandom), 16'($urandom));
    end
    @(posedge clk); #1;
    checkOutput("rst out_valid", 128'(outValid), 128'(0));
    checkOutput("rst out_ctrl",  128'(outCtrl),  128'(NOP));
    checkOutput("rst out_data",  128'(outData),  128'(0));
    checkOutput("rst occupancy", 128'(occ),      128'(0));
    checkOutput("rst in_ready",  128'(inReady),  128'(0));
    checkOutput("rst halted",    128'(haltedOut), 128'(0));
    checkOutput("rst0 in_ready", 128'(inReady0), 128'(0));
    checkOutput("rst0 out_ctrl", 128'(outCtrl0), 128'(NOP));

    @(negedge clk);
    applyStimulus(0, 0, 0, 16'h0, 16'h0);
    drive0(0, 0, 16'h0);
    rst = 1'b1;
    #1;
    checkOutput("release in_ready0 before edge", 128'(inReady0), 128'(0));
    @(posedge clk); #1;
    checkOutput("release in_ready",  128'(inReady),  128'(1));
    checkOutput("release in_ready0", 128'(inReady0), 128'(1));
    checkOutput("release out_valid", 128'(outValid), 128'(0));

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].iv, vecs[i].orr, vecs[i].fl, vecs[i].f, vecs[i].c);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d out_valid", i), 128'(outValid),  128'(vecs[i].eov));
      checkOutput($sformatf("v%0d out_data", i),  128'(outData),   128'(mk(vecs[i].eod)));
      checkOutput($sformatf("v%0d out_ctrl", i),  128'(outCtrl),   128'(vecs[i].eoc));
      checkOutput($sformatf("v%0d occupancy", i), 128'(occ),       128'(vecs[i].eocc));
      checkOutput($sformatf("v%0d in_ready", i),  128'(inReady),   128'(vecs[i].eir));
      checkOutput($sformatf("v%0d halted", i),    128'(haltedOut), 128'(vecs[i].ehl));
    end

    // Asynchronous reset in the middle of a full stage.
    @(negedge clk); applyStimulus(1, 0, 0, 16'h00B1, 16'h01B1);
    @(negedge clk); applyStimulus(1, 0, 0, 16'h00B2, 16'h01B2);
    @(negedge clk);
    checkOutput("pre-reset occupancy", 128'(occ), 128'(2));
    applyStimulus(0, 0, 0, 16'h0, 16'h0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async rst occupancy", 128'(occ),      128'(0));
    checkOutput("async rst out_valid", 128'(outValid), 128'(0));
    checkOutput("async rst out_data",  128'(outData),  128'(0));
    checkOutput("async rst in_ready",  128'(inReady),  128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("re-release in_ready0", 128'(inReady0), 128'(1));

    // Single-entry build: out_ready toggles while in_valid stays high.
    @(negedge clk); drive0(1, 1, 16'h0031); #1;
    checkOutput("s0 A in_ready", 128'(inReady0), 128'(1));
    @(posedge clk); #1;
    checkOutput("s0 A data", 128'(outData0), 128'(mk(16'h0031)));
    checkOutput("s0 A occ",  128'(occ0),     128'(1));
    @(negedge clk); drive0(1, 0, 16'h0032); #1;
    checkOutput("s0 B in_ready", 128'(inReady0), 128'(0));
    @(posedge clk); #1;
    checkOutput("s0 B data", 128'(outData0), 128'(mk(16'h0031)));
    checkOutput("s0 B occ",  128'(occ0),     128'(1));
    @(negedge clk); drive0(1, 1, 16'h0032); #1;
    checkOutput("s0 C in_ready", 128'(inReady0), 128'(1));
    @(posedge clk); #1;
    checkOutput("s0 C data", 128'(outData0), 128'(mk(16'h0032)));
    checkOutput("s0 C ctrl", 128'(outCtrl0), 128'(16'h0132));
    checkOutput("s0 C occ",  128'(occ0),     128'(1));
    @(negedge clk); drive0(1, 0, 16'h0033); #1;
    checkOutput("s0 D in_ready", 128'(inReady0), 128'(0));
    @(posedge clk); #1;
    checkOutput("s0 D data", 128'(outData0), 128'(mk(16'h0032)));
    @(negedge clk); drive0(1, 1, 16'h0033); #1;
    checkOutput("s0 E in_ready", 128'(inReady0), 128'(1));
    @(posedge clk); #1;
    checkOutput("s0 E data", 128'(outData0), 128'(mk(16'h0033)));
    checkOutput("s0 E occ",  128'(occ0),     128'(1));
    @(negedge clk); drive0(0, 1, 16'h0000); #1;
    @(posedge clk); #1;
    checkOutput("s0 F out_valid", 128'(outValid0), 128'(0));
    checkOutput("s0 F out_ctrl",  128'(outCtrl0),  128'(NOP));
    checkOutput("s0 F occ",       128'(occ0),      128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
